// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: frame sequencer in front of the 8-point FFT core.
// Collects eight complex samples, presents them in parallel to the core,
// waits out the core latency, captures the eight bins and streams them out
// one per valid/ready handshake with a last flag on bin 7.
//
// Optional feature macro: FFT8_CTRL_OVERLAP_EN
//   defined   - the next frame may load while the current one drains
//   undefined - loading only happens in the LOAD state
module fft8_frame_ctrl #(
    parameter int DATA_W   = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_re,
    input  logic [DATA_W-1:0]   in_im,
    output logic [8*DATA_W-1:0] fft_x_re,
    output logic [8*DATA_W-1:0] fft_x_im,
    input  logic [8*DATA_W-1:0] fft_y_re,
    input  logic [8*DATA_W-1:0] fft_y_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_re,
    output logic [DATA_W-1:0]   out_im,
    output logic                out_last,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    // Run counter must hold 0..PIPE_LAT; keep at least one bit.
    localparam int CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(PIPE_LAT);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_r;
    logic [DATA_W-1:0] xin_re_r  [8];
    logic [DATA_W-1:0] xin_im_r  [8];
    logic [DATA_W-1:0] ybuf_re_r [8];
    logic [DATA_W-1:0] ybuf_im_r [8];
    logic [2:0]        ld_idx_r;
    logic [2:0]        rd_idx_r;
    logic [CW-1:0]     run_cnt_r;
    logic [15:0]       frame_cnt_r;

    logic              accept_s;
    logic              out_hs_s;
    logic              fill_done_s;

`ifdef FFT8_CTRL_OVERLAP_EN
    // Set once all eight samples of the next frame are held during DRAIN.
    logic              ld_full_r;
`endif

    // Input readiness decoded from registered state only.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_LOAD:  in_ready = 1'b1;
`ifdef FFT8_CTRL_OVERLAP_EN
            ST_DRAIN: in_ready = ~ld_full_r;
`else
            ST_DRAIN: in_ready = 1'b0;
`endif
            ST_RUN:   in_ready = 1'b0;
            default:  in_ready = 1'b0;
        endcase
    end

    // Output side is a pure decode of state and the read pointer.
    always_comb begin
        out_valid = (state_r == ST_DRAIN);
        out_last  = (state_r == ST_DRAIN) && (rd_idx_r == 3'd7);
        out_re    = ybuf_re_r[rd_idx_r];
        out_im    = ybuf_im_r[rd_idx_r];
        busy      = (state_r != ST_LOAD) || (ld_idx_r != 3'd0);
        frame_cnt = frame_cnt_r;
    end

    // Handshake strobes used by the sequential blocks.
    always_comb begin
        accept_s    = in_valid && in_ready;
        out_hs_s    = out_valid && out_ready;
        fill_done_s = accept_s && (ld_idx_r == 3'd7);
    end

    // Input frame register drives the FFT lanes directly, natural order.
    always_comb begin
        fft_x_re = '0;
        fft_x_im = '0;
        for (int k = 0; k < 8; k++) begin
            fft_x_re[k*DATA_W +: DATA_W] = xin_re_r[k];
            fft_x_im[k*DATA_W +: DATA_W] = xin_im_r[k];
        end
    end

    // Sample loading: write the current lane and advance the load index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_idx_r <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                xin_re_r[k] <= '0;
                xin_im_r[k] <= '0;
            end
        end else if (accept_s) begin
            xin_re_r[ld_idx_r] <= in_re;
            xin_im_r[ld_idx_r] <= in_im;
            ld_idx_r           <= ld_idx_r + 3'd1;
        end
    end

`ifdef FFT8_CTRL_OVERLAP_EN
    // Track a complete next frame that arrived before the drain finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_full_r <= 1'b0;
        end else if ((state_r == ST_DRAIN) && out_hs_s && (rd_idx_r == 3'd7)) begin
            // Leaving DRAIN: a full frame (held or just completed) moves to RUN.
            ld_full_r <= 1'b0;
        end else if ((state_r == ST_DRAIN) && fill_done_s) begin
            ld_full_r <= 1'b1;
        end else begin
            ld_full_r <= ld_full_r;
        end
    end
`endif

    // Main sequencer: LOAD -> RUN (core latency) -> DRAIN (serial output).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            run_cnt_r   <= '0;
            rd_idx_r    <= 3'd0;
            frame_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (fill_done_s) begin
                        state_r   <= ST_RUN;
                        run_cnt_r <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_cnt_r == RUN_LAST) begin
                        state_r  <= ST_DRAIN;
                        rd_idx_r <= 3'd0;
                    end else begin
                        run_cnt_r <= run_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    if (out_hs_s) begin
                        if (rd_idx_r == 3'd7) begin
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                            rd_idx_r    <= 3'd0;
                            run_cnt_r   <= '0;
`ifdef FFT8_CTRL_OVERLAP_EN
                            if (ld_full_r || fill_done_s) begin
                                state_r <= ST_RUN;
                            end else begin
                                state_r <= ST_LOAD;
                            end
`else
                            state_r <= ST_LOAD;
`endif
                        end else begin
                            rd_idx_r <= rd_idx_r + 3'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    // Result capture on the final RUN cycle; buffer is stable through DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                ybuf_re_r[k] <= '0;
                ybuf_im_r[k] <= '0;
            end
        end else if ((state_r == ST_RUN) && (run_cnt_r == RUN_LAST)) begin
            for (int k = 0; k < 8; k++) begin
                ybuf_re_r[k] <= fft_y_re[k*DATA_W +: DATA_W];
                ybuf_im_r[k] <= fft_y_im[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Self-checking bench for fft8_frame_ctrl. The FFT core is stood in for by
// a lane-echo pipeline of PIPE_LAT stages; a frame-level reference model
// predicts handshakes, output bins and counters every cycle.
module tb_fft8_frame_ctrl;

    localparam int DW = 16;
    localparam int PL = 3;
`ifdef FFT8_CTRL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic [8*DW-1:0] fft_x_re;
    logic [8*DW-1:0] fft_x_im;
    logic [8*DW-1:0] fft_y_re;
    logic [8*DW-1:0] fft_y_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_last;
    logic          busy;
    logic [15:0]   frame_cnt;

    fft8_frame_ctrl #(.DATA_W(DW), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .fft_x_re(fft_x_re), .fft_x_im(fft_x_im),
        .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FFT core: lane echo delayed by PL register stages.
    logic [8*DW-1:0] pipe_re [PL];
    logic [8*DW-1:0] pipe_im [PL];
    always @(posedge clk) begin
        pipe_re[0] <= fft_x_re;
        pipe_im[0] <= fft_x_im;
        for (int i = 1; i < PL; i++) begin
            pipe_re[i] <= pipe_re[i-1];
            pipe_im[i] <= pipe_im[i-1];
        end
    end
    assign fft_y_re = pipe_re[PL-1];
    assign fft_y_im = pipe_im[PL-1];

    // Reference model: frame-level bookkeeping.
    int          held, run_cnt, rd, fcnt, cyc_n;
    bit          running, draining, prev_ov;
    logic [DW-1:0] xm_re [8], xm_im [8], fr_re [8], fr_im [8], yb_re [8], yb_im [8];
    int          rises [$];
    int          passed, total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    endtask

    task automatic model_reset();
        held = 0; run_cnt = 0; rd = 0; fcnt = 0;
        running = 1'b0; draining = 1'b0; prev_ov = 1'b0;
        for (int k = 0; k < 8; k++) begin
            yb_re[k] = '0; yb_im[k] = '0; xm_re[k] = '0; xm_im[k] = '0;
        end
    endtask

    task automatic start_run();
        fr_re = xm_re; fr_im = xm_im;
        held = 0; running = 1'b1; run_cnt = 0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input bit ordy, output bit acc);
        bit wl, wr, wd, want_ir, hs;
        @(negedge clk);
        in_valid = v; in_re = re; in_im = im; out_ready = ordy;
        #1;
        wl = !running && !draining; wr = running; wd = draining;
        want_ir = wl ? 1'b1 : (OVL && draining && (held < 8));
        chk("in_ready", 64'(in_ready), 64'(want_ir));
        chk("out_valid", 64'(out_valid), 64'(draining));
        chk("out_last", 64'(out_last), 64'(draining && (rd == 7)));
        chk("busy", 64'(busy), 64'(running || draining || (held != 0)));
        chk("frame_cnt", 64'(frame_cnt), 64'(fcnt[15:0]));
        if (draining) begin
            chk("out_re", 64'(out_re), 64'(yb_re[rd]));
            chk("out_im", 64'(out_im), 64'(yb_im[rd]));
        end
        if (out_valid && !prev_ov) rises.push_back(cyc_n);
        prev_ov = out_valid;
        acc = v && want_ir;
        hs = draining && ordy;
        if (acc) begin
            xm_re[held] = re; xm_im[held] = im; held++;
        end
        if (wl && held == 8) start_run();
        if (wr) begin
            if (run_cnt == PL) begin
                yb_re = fr_re; yb_im = fr_im;
                running = 1'b0; draining = 1'b1; rd = 0;
            end else run_cnt++;
        end
        if (wd && hs) begin
            if (rd == 7) begin
                fcnt = (fcnt + 1) & 16'hFFFF;
                draining = 1'b0;
                if (held == 8) start_run();
            end else rd++;
        end
        cyc_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_x_zero", 64'(|{fft_x_re, fft_x_im}), 64'd0);
        chk("rst_out_zero", 64'({out_re, out_im}), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit a;
        int t0, n;
        logic [DW-1:0] r1, r2;
        passed = 0; total = 0; cyc_n = 0;
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Ramp frame: re=k, im=-k, back-to-back, out_ready=1.
        rises.delete();
        t0 = cyc_n;
        for (int k = 0; k < 8; k++) step(1'b1, 16'(k), 16'(-k), 1'b1, a);
        repeat (14) step(1'b0, 16'd0, 16'd0, 1'b1, a);
        chk("ramp_first_out_cycle", 64'(rises.size() > 0 ? rises[0] - t0 : -1), 64'(9 + PL));
        chk("ramp_frame_cnt", 64'(frame_cnt), 64'd1);

        // Impulse frame: all echo lanes except lane 0 are zero.
        for (int k = 0; k < 8; k++) step(1'b1, (k == 0) ? 16'h0100 : 16'd0, 16'd0, 1'b1, a);
        repeat (14) step(1'b0, 16'd0, 16'd0, 1'b1, a);

        // out_ready alternating during drain, input held high throughout.
        for (int i = 0; i < 60; i++) begin
            r1 = 16'($urandom); r2 = 16'($urandom);
            step(1'b1, r1, r2, (i % 2) == 0, a);
        end

        // Random traffic: gaps on both sides.
        for (int i = 0; i < 300; i++) begin
            r1 = 16'($urandom); r2 = 16'($urandom);
            step($urandom_range(0, 3) != 0, r1, r2, $urandom_range(0, 1) == 1, a);
        end
        repeat (30) step(1'b0, 16'd0, 16'd0, 1'b1, a);

        // Reset in cycle 5 of a LOAD.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 16'(100 + k), 16'(k), 1'b1, a);
        do_reset();
        step(1'b0, 16'd0, 16'd0, 1'b1, a);

        // Reset mid-DRAIN.
        for (int k = 0; k < 8; k++) step(1'b1, 16'(200 + k), 16'(k), 1'b1, a);
        repeat (7) step(1'b0, 16'd0, 16'd0, 1'b1, a);
        chk("pre_rst_draining", 64'(out_valid), 64'd1);
        do_reset();
        step(1'b0, 16'd0, 16'd0, 1'b1, a);

        // Two back-to-back frames with in_valid held high.
        rises.delete();
        t0 = cyc_n; n = 0;
        while (n < 16) begin
            step(1'b1, 16'(300 + n), 16'(n), 1'b1, a);
            if (a) n++;
            if (cyc_n - t0 > 100) break;
        end
        chk("b2b_all_accepted", 64'(n), 64'd16);
        while (cyc_n - t0 < 50) step(1'b0, 16'd0, 16'd0, 1'b1, a);
        chk("b2b_rises", 64'(rises.size()), 64'd2);
        chk("b2b_first_out", 64'(rises.size() > 0 ? rises[0] - t0 : -1), 64'(9 + PL));
        chk("b2b_second_out", 64'(rises.size() > 1 ? rises[1] - t0 : -1),
            64'(OVL ? 2 * (9 + PL) : 16 + PL + 1 + 9 + PL));
        chk("b2b_frame_cnt", 64'(frame_cnt), 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fft8_frame_ctrl.md
# fft8_frame_ctrl

Frame sequencer for the 8-point FFT core. Accepts complex samples one per handshake, assembles an 8-sample frame, and presents it in parallel to the FFT datapath. It holds the inputs stable for the fixed pipeline latency, captures the 8 results, then streams them out serially with valid/ready and a last flag. It sits between the sample stream interface and the `basic_fft8` instance, and is the only block that drives the FFT inputs.

## Interface
- `DATA_W`, 16: sample component width, two's complement.
- `PIPE_LAT`, 3: FFT core latency in cycles, input change to stable output.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: controller can accept a sample.
- `in_re`, `in_im` in DATA_W: input sample.
- `fft_x_re`, `fft_x_im` out 8*DATA_W: frame to the FFT; lane k at `[k*DATA_W +: DATA_W]`, natural order (core does bit reversal).
- `fft_y_re`, `fft_y_im` in 8*DATA_W: FFT results, same lane packing.
- `out_valid` out 1: output bin valid.
- `out_ready` in 1: downstream accepts bin.
- `out_re`, `out_im` out DATA_W: output bin, index 0..7 in order.
- `out_last` out 1: high with bin 7.
- `busy` out 1: state is not LOAD, or load count is nonzero.
- `frame_cnt` out 16: completed frames (bin 7 handshakes), wraps 0xFFFF→0.

## Operation
- Storage: input frame register `xin[0:7]` (drives `fft_x_*` directly), output buffer `ybuf[0:7]`, 3-bit `ld_idx`, 3-bit `rd_idx`, run counter of width clog2(PIPE_LAT+1).
- States:
  - LOAD:
    - `in_ready`=1.
    - Each `in_valid&&in_ready` writes `xin[ld_idx]` and increments `ld_idx`.
    - On the 8th accept, `ld_idx` wraps to 0 and the state goes to RUN.
  - RUN:
    - `in_ready`=0, `xin` frozen; the run counter counts 0..PIPE_LAT.
    - On the edge where the counter equals PIPE_LAT, `ybuf` ← `fft_y_*`, `rd_idx`←0, and the state goes to DRAIN.
  - DRAIN:
    - `out_valid`=1; `out_re`/`out_im` = `ybuf[rd_idx]`; `out_last` = (`rd_idx`==7).
    - Each `out_valid&&out_ready` increments `rd_idx`.
    - On the bin-7 handshake, `frame_cnt`++ and the next state is LOAD (see Configuration for overlap).
- `out_*` must not change while `out_valid`=1 and `out_ready`=0.
- `in_valid` while `in_ready`=0: ignored; the sample is not stored.
- Reset (any time, including mid-frame):
  - state=LOAD; `ld_idx`, `rd_idx`, run counter, `frame_cnt` = 0.
  - `xin`, `ybuf` = 0; `out_valid`=0, `out_last`=0.
  - A partially loaded or partially drained frame is discarded.
- No arithmetic is done here. Data passes bit-exact; widths are unchanged.

## Timing
- Cycle 0 = first accepted sample; with back-to-back input and `out_ready`=1, PIPE_LAT=3:
  - Accepts occur in cycles 0–7.
  - RUN covers cycles 8–11 (PIPE_LAT+1 cycles). Capture happens at the end of cycle 11.
  - `out_valid` rises in cycle 12, and `out_last` is high in cycle 19.
- Input-to-first-output latency: 9+PIPE_LAT cycles after the first sample (12 cycles at PIPE_LAT=3).
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid`/`out_ready`.
- After reset release: `in_ready`=1 and `out_valid`=0 in the first cycle.

## Configuration
- `FFT8_CTRL_OVERLAP_EN`:
  - Defined:
    - `in_ready`=1 during DRAIN while fewer than 8 samples of the next frame are held; loading into `xin` continues (`ybuf` is independent).
    - On the bin-7 handshake, go to RUN if 8 samples are held, otherwise LOAD with `ld_idx` preserved.
    - Same-cycle 8th accept and bin-7 handshake → RUN.
    - Steady-state frame period is 8+PIPE_LAT+1 cycles (12 at default).
  - Undefined:
    - `in_ready`=0 outside LOAD.
    - Frame period is 16+PIPE_LAT+1 cycles (20 at default).

## Test plan
- Reset, then samples re=k, im=−k for k=0..7 back-to-back, `out_ready`=1, FFT model with lane echo → `out_re`=0..7 in cycles 12–19, `out_last` only in cycle 19, `frame_cnt`=1.
- Real FFT instance, impulse (x0=0x0100, rest 0) → all 8 bins re=0x0100, im=0.
- `out_ready` toggled 1-0-1-0 during DRAIN → each bin held stable while stalled; exactly 8 handshakes; bin order 0..7.
- `in_valid` held high through RUN → no extra samples stored; next frame starts with sample 8 at lane 0.
- Assert `rst` in cycle 5 of LOAD and again mid-DRAIN → outputs zero, `out_valid`=0, `frame_cnt`=0, `in_ready`=1 in the cycle after release.
- With `FFT8_CTRL_OVERLAP_EN`, two back-to-back frames → second frame's `out_valid` rises 12 cycles after the first frame's (cycle 24); without the macro it rises in cycle 32.
